// File: rtl/serial_adder8.sv
// serial_adder8
//   Bit-serial adder: computes a + b + ci one bit per clock, LSB first,
//   through a single 1-bit full adder and a carry flip-flop. The result
//   is published on sum/co together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/sum width in bits (2..32)
//
// Ports
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   start  begin an addition (only sampled while idle)
//   a, b   operands, captured on the accepting edge
//   ci     carry-in, captured on the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle pulse, sum/co valid from this cycle on
//   sum    registered result, low WIDTH bits of a + b + ci
//   co     registered carry-out of the final bit
module serial_adder8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] res_nx;

    // Single full adder shared by every bit position.
    always_comb begin
        fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        res_nx   = {fa_s, res_sr[WIDTH-1:1]};
        last_bit = (bit_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath. sum/co are written only on the final RUN edge, so the
    // partially built result in res_sr is never visible on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            co      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= ci;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_nx;
                    carry   <= fa_c;
                    if (last_bit) begin
                        sum <= res_nx;
                        co  <= fa_c;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder8.sv
module tb_serial_adder8;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [7:0] s;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ci = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       co;

    serial_adder8 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .co   (co)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   passed = 0;
    exp_t sb[$];
    int   pushes = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   busy_run = 0;
    bit   in_sweep = 0;
    bit   prev_sweep = 0;
    bit   rst_edge = 0;
    logic [7:0] hold_s = '0;
    logic       hold_c = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input logic [7:0] s, input logic c);
        exp_t e;
        e.s = s;
        e.c = c;
        sb.push_back(e);
        pushes++;
    endtask

    always @(posedge clk) rst_edge = !rst_n;

    // Monitor: pops the scoreboard on every done pulse, and between pulses
    // checks that sum/co keep the last published result.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_edge) begin
            hold_s   = '0;
            hold_c   = 1'b0;
            busy_run = 0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("done_with_empty_queue", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("co", 32'(co), 32'(e.c));
                hold_s = e.s;
                hold_c = e.c;
            end
            check("busy_cycles_before_done", 32'(busy_run), 32'(WIDTH));
            busy_run = 0;
            if (in_sweep && prev_sweep)
                check("done_spacing", 32'(cyc - last_done_cyc), 32'(WIDTH + 2));
            prev_sweep    = in_sweep;
            last_done_cyc = cyc;
        end else begin
            if (busy === 1'b1) busy_run++;
            check("result_hold", {23'd0, co, sum}, {23'd0, hold_c, hold_s});
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 30; k++) begin
            if (busy === 1'b0 && done === 1'b0) return;
            @(posedge clk); #1;
        end
        timeout_fail("wait_idle");
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 40; k++) begin
            if (done_cnt >= target) return;
            @(posedge clk); #1;
        end
        timeout_fail("wait_done");
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                         input logic [7:0] es, input logic ec);
        int d0;
        wait_idle();
        d0    = done_cnt;
        a     = ta;
        b     = tb_;
        ci    = tci;
        start = 1'b1;
        push_exp(es, ec);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0 + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         d0;
        bit         ok;
        logic [8:0] ref9;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_co", 32'(co), 32'd0);

        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        do_op(8'h0F, 8'h01, 1'b1, 8'h11, 1'b0);
        do_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);

        // Second request and operand changes during RUN must be ignored.
        wait_idle();
        d0 = done_cnt;
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        push_exp(8'h46, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        a = 8'hFF; b = 8'hFF; ci = 1'b1; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0; a = '0; b = '0; ci = 1'b0;
        wait_done(d0 + 1);
        repeat (12) begin @(posedge clk); #1; end
        check("single_done_after_ignored_start", 32'(done_cnt), 32'(d0 + 1));

        // Reset on the 4th RUN edge aborts the operation without a done.
        wait_idle();
        d0 = done_cnt;
        a = 8'h55; b = 8'h11; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        repeat (12) begin @(posedge clk); #1; end
        check("no_done_after_abort", 32'(done_cnt), 32'(d0));
        do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

        // Back-to-back sweep with start held high; operands change right
        // after each acceptance, i.e. while the previous op is running.
        wait_idle();
        in_sweep = 1'b1;
        d0 = done_cnt;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 15; k++) begin
                @(posedge clk); #1;
                if (busy === 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) begin timeout_fail("sweep_accept"); break; end
            ref9 = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            push_exp(ref9[7:0], ref9[8]);
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            if (i == 999) start = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 15; k++) begin
                @(posedge clk); #1;
                if (busy === 1'b0) begin ok = 1'b1; break; end
            end
            if (!ok) begin timeout_fail("sweep_run"); break; end
        end
        start = 1'b0;
        wait_done(d0 + 1000);
        in_sweep = 1'b0;
        repeat (5) begin @(posedge clk); #1; end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'(pushes));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
